// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU: operand register, then result/flag register.
// Define ALU_SHIFT_EN to enable SLL/SRL/SRA on op codes 3/4/5.
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [3:0]       ALU_control,
  input  logic [2:0]       bonus_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             cout,
  output logic             overflow,
  output logic             ovf_sticky,
  input  logic             clr_sticky,
  output logic [CNT_W-1:0] op_count
);

  localparam int M = WIDTH - 1;

  logic             s1_v_q, s2_v_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [3:0]       op_q;
  logic [2:0]       bn_q;
  logic [WIDTH-1:0] res_q, res_d;
  logic             z_q, z_d, c_q, c_d, v_q, v_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             s1_adv, s2_adv, out_xfer;
  logic [WIDTH:0]   sum, dif;
  logic             add_v, sub_v, lt, eq, cond;

  assign s2_adv   = !s2_v_q || out_ready;
  assign s1_adv   = !s1_v_q || s2_adv;
  assign in_ready = s1_adv;
  assign out_xfer = s2_v_q && out_ready;

  assign out_valid  = s2_v_q;
  assign result     = res_q;
  assign zero       = z_q;
  assign cout       = c_q;
  assign overflow   = v_q;
  assign ovf_sticky = sticky_q;
  assign op_count   = cnt_q;

`ifdef ALU_SHIFT_EN
  localparam int SW = $clog2(WIDTH);
  logic [SW-1:0] sh;
  logic [WIDTH:0] sll, srl, sra;
  assign sh  = a_q[SW-1:0];
  // One extra bit catches the last bit shifted out.
  assign sll = {1'b0, b_q} << sh;
  assign srl = {b_q, 1'b0} >> sh;
  assign sra = $signed({b_q, 1'b0}) >>> sh;
`endif

  always_comb begin
    sum   = {1'b0, a_q} + {1'b0, b_q};
    dif   = {1'b0, a_q} + {1'b0, ~b_q}
          + {{WIDTH{1'b0}}, 1'b1};
    add_v = (a_q[M] == b_q[M]) && (sum[M] != a_q[M]);
    sub_v = (a_q[M] != b_q[M]) && (dif[M] != a_q[M]);
    lt    = dif[M] ^ sub_v;
    eq    = (a_q == b_q);
    case (bn_q)
      3'd0:    cond = lt;
      3'd1:    cond = !lt && !eq;
      3'd2:    cond = lt || eq;
      3'd3:    cond = !lt;
      3'd4:    cond = eq;
      3'd5:    cond = !eq;
      default: cond = 1'b0;
    endcase
    res_d = '0;
    c_d   = 1'b0;
    v_d   = 1'b0;
    case (op_q)
      4'd0:  res_d = a_q & b_q;
      4'd1:  res_d = a_q | b_q;
      4'd2: begin
        res_d = sum[M:0];
        c_d   = sum[WIDTH];
        v_d   = add_v;
      end
      4'd6: begin
        res_d = dif[M:0];
        c_d   = dif[WIDTH];
        v_d   = sub_v;
      end
      4'd7: begin
        res_d = {{M{1'b0}}, cond};
        c_d   = dif[WIDTH];
        v_d   = sub_v;
      end
      4'd12: res_d = ~(a_q | b_q);
      4'd13: res_d = ~(a_q & b_q);
`ifdef ALU_SHIFT_EN
      4'd3: begin
        res_d = sll[M:0];
        c_d   = sll[WIDTH];
      end
      4'd4: begin
        res_d = srl[WIDTH:1];
        c_d   = srl[0];
      end
      4'd5: begin
        res_d = sra[WIDTH:1];
        c_d   = sra[0];
      end
`endif
      default: res_d = '0;
    endcase
    z_d = (res_d == '0);
    cnt_d = out_xfer ? cnt_q + CNT_W'(1) : cnt_q;
    // A same-cycle set beats the clear.
    if (out_xfer && v_q)
      sticky_d = 1'b1;
    else if (clr_sticky)
      sticky_d = 1'b0;
    else
      sticky_d = sticky_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q   <= 1'b0;
      s2_v_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      bn_q     <= '0;
      res_q    <= '0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (s1_adv) begin
        s1_v_q <= in_valid;
        if (in_valid) begin
          a_q  <= src1;
          b_q  <= src2;
          op_q <= ALU_control;
          bn_q <= bonus_control;
        end
      end
      if (s2_adv) begin
        s2_v_q <= s1_v_q;
        if (s1_v_q) begin
          res_q <= res_d;
          z_q   <= z_d;
          c_q   <= c_d;
          v_q   <= v_d;
        end
      end
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
